// File: rtl/core_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : core_sequencer_if
// Description : Control/status bundle between the instruction sequencer and
//               its decoder, instruction memory and data memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface core_sequencer_if;
    logic        run;
    logic        dec_mem_read;
    logic        dec_mem_write;
    logic        dec_reg_write;
    logic        dec_illegal;
    logic        dmem_ready;
    logic        imem_en;
    logic        ir_we;
    logic        pc_we;
    logic        rf_we;
    logic        dmem_req;
    logic        dmem_we;
    logic [2:0]  state;
    logic        retired;
    logic [63:0] instret;
    logic [63:0] cycles;
    logic        fault;

    // Driver side: decoder, memories and run control
    modport master (
        output run, dec_mem_read, dec_mem_write, dec_reg_write, dec_illegal, dmem_ready,
        input  imem_en, ir_we, pc_we, rf_we, dmem_req, dmem_we, state, retired,
        input  instret, cycles, fault
    );

    // Sequencer side
    modport slave (
        input  run, dec_mem_read, dec_mem_write, dec_reg_write, dec_illegal, dmem_ready,
        output imem_en, ir_we, pc_we, rf_we, dmem_req, dmem_we, state, retired,
        output instret, cycles, fault
    );
endinterface
`default_nettype wire

// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : core_sequencer
// Description : Multi-cycle instruction sequencer FETCH/FWAIT/EXEC/MEM/WB with
//               retire and active-cycle counters and a sticky fault/HALT.
// Revision    : 1.0 - initial release
// ============================================================================
module core_sequencer #(
    parameter int IMEM_LAT    = 1,
    parameter int MEM_TIMEOUT = 16
) (
    input  wire logic       clk,
    input  wire logic       reset,
    core_sequencer_if.slave bus
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_FETCH = 3'd1;
    localparam logic [2:0] c_FWAIT = 3'd2;
    localparam logic [2:0] c_EXEC  = 3'd3;
    localparam logic [2:0] c_MEM   = 3'd4;
    localparam logic [2:0] c_WB    = 3'd5;
    localparam logic [2:0] c_HALT  = 3'd6;

    localparam logic [2:0] c_FWAIT_LAST = 3'(IMEM_LAT - 1);
    localparam logic [7:0] c_MEM_LAST   = 8'(MEM_TIMEOUT - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [2:0]  r_fwait_cnt;
    logic [7:0]  r_mem_cnt;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_reg_write;
    logic        r_fault;
    logic [63:0] r_instret;
    logic [63:0] r_cycles;
    logic        w_set_fault;
    logic        w_fwait_done;
    logic        w_mem_timeout;
    logic        w_active;

    assign w_fwait_done  = (r_fwait_cnt == c_FWAIT_LAST);
    assign w_mem_timeout = (r_mem_cnt == c_MEM_LAST);
    assign w_active      = (r_state != c_IDLE) && (r_state != c_HALT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_set_fault  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (bus.run) begin
                    w_next_state = c_FETCH;
                end
            end
            c_FETCH: begin
                w_next_state = c_FWAIT;
            end
            c_FWAIT: begin
                if (w_fwait_done) begin
                    w_next_state = c_EXEC;
                end
            end
            c_EXEC: begin
                if (bus.dec_illegal) begin
                    w_next_state = c_HALT;
                    w_set_fault  = 1'b1;
                end else if (bus.dec_mem_read || bus.dec_mem_write) begin
                    w_next_state = c_MEM;
                end else begin
                    w_next_state = c_WB;
                end
            end
            c_MEM: begin
                // A ready on the final allowed cycle still completes
                if (bus.dmem_ready) begin
                    w_next_state = c_WB;
                end else if (w_mem_timeout) begin
                    w_next_state = c_HALT;
                    w_set_fault  = 1'b1;
                end
            end
            c_WB: begin
                w_next_state = bus.run ? c_FETCH : c_IDLE;
            end
            c_HALT: begin
                w_next_state = c_HALT;
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fwait_cnt <= 3'd0;
        end else if ((r_state == c_FWAIT) && !w_fwait_done) begin
            r_fwait_cnt <= r_fwait_cnt + 3'd1;
        end else begin
            r_fwait_cnt <= 3'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_cnt <= 8'd0;
        end else if ((r_state == c_MEM) && !bus.dmem_ready && !w_mem_timeout) begin
            r_mem_cnt <= r_mem_cnt + 8'd1;
        end else begin
            r_mem_cnt <= 8'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_reg_write <= 1'b0;
        end else if (r_state == c_EXEC) begin
            r_mem_read  <= bus.dec_mem_read;
            r_mem_write <= bus.dec_mem_write;
            r_reg_write <= bus.dec_reg_write;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else if (w_set_fault) begin
            r_fault <= 1'b1;
        end
    end

    // Counters wrap silently; HALT and IDLE are excluded by w_active
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instret <= 64'd0;
            r_cycles  <= 64'd0;
        end else begin
            if (w_active) begin
                r_cycles <= r_cycles + 64'd1;
            end
            if (r_state == c_WB) begin
                r_instret <= r_instret + 64'd1;
            end
        end
    end

    assign bus.state    = r_state;
    assign bus.imem_en  = (r_state == c_FETCH);
    assign bus.ir_we    = (r_state == c_FWAIT) && w_fwait_done;
    assign bus.dmem_req = (r_state == c_MEM) && (r_mem_read || r_mem_write);
    assign bus.dmem_we  = (r_state == c_MEM) && r_mem_write;
    assign bus.pc_we    = (r_state == c_WB);
    assign bus.retired  = (r_state == c_WB);
    assign bus.rf_we    = (r_state == c_WB) && r_reg_write;
    assign bus.instret  = r_instret;
    assign bus.cycles   = r_cycles;
    assign bus.fault    = r_fault;

endmodule
`default_nettype wire

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL provide parameter IMEM_LAT, default 1, instruction-memory read latency in cycles, legal range 1..7.
REQ-002 SHALL provide parameter MEM_TIMEOUT, default 16, maximum MEM-state cycles to wait for dmem_ready before faulting, legal range 2..255.
REQ-003 SHALL use one clock; reset is asynchronous and active-high; ports named clk and reset.
REQ-004 SHALL have these ports:
- clk, in, 1, system clock (rising edge)
- reset, in, 1, asynchronous active-high reset
- run, in, 1, level enable to start or continue sequencing
- dec_mem_read, in, 1, decoded load
- dec_mem_write, in, 1, decoded store
- dec_reg_write, in, 1, decoded register writeback
- dec_illegal, in, 1, decoded illegal opcode
- dmem_ready, in, 1, data-memory access complete
- imem_en, out, 1, instruction-memory read enable
- ir_we, out, 1, instruction-register load
- pc_we, out, 1, PC update enable
- rf_we, out, 1, register-file write enable
- dmem_req, out, 1, data-memory request
- dmem_we, out, 1, data-memory write
- state, out, 3, current state encoding
- retired, out, 1, one-cycle instruction-retire pulse
- instret, out, 64, retired-instruction count
- cycles, out, 64, active-cycle count
- fault, out, 1, sticky fault flag

Function
REQ-005 SHALL implement states IDLE=0, FETCH=1, FWAIT=2, EXEC=3, MEM=4, WB=5, HALT=6; state output SHALL equal the registered state.
REQ-006 IDLE SHALL go to FETCH when run=1 and otherwise hold.
REQ-007 FETCH SHALL assert imem_en for exactly one cycle, then go to FWAIT.
REQ-008 FWAIT SHALL last exactly IMEM_LAT cycles and assert ir_we only on its last cycle, then go to EXEC.
REQ-009 EXEC SHALL last one cycle and latch dec_mem_read, dec_mem_write and dec_reg_write.
- dec_illegal=1 -> HALT, with fault set.
- otherwise dec_mem_read or dec_mem_write -> MEM.
- otherwise -> WB.
REQ-010 MEM SHALL hold dmem_req=1 on every MEM cycle, with dmem_we equal to the latched write flag.
- Write has priority when both read and write are latched.
REQ-011 MEM SHALL go to WB in the cycle after dmem_ready is sampled 1.
- dmem_ready on the first MEM cycle gives a one-cycle MEM.
REQ-012 MEM SHALL go to HALT with fault set if dmem_ready is still 0 after MEM_TIMEOUT MEM cycles.
- MEM_TIMEOUT=16: a ready on cycle 16 completes; none by cycle 16 halts.
REQ-013 dmem_ready SHALL be ignored outside MEM.
REQ-014 WB SHALL last one cycle and assert pc_we=1, retired=1 and rf_we equal to the latched reg-write flag.
REQ-015 WB SHALL increment instret by 1, then go to FETCH if run=1, else IDLE.
REQ-016 Deasserting run mid-instruction SHALL NOT abort it; the instruction completes through WB, then the FSM goes to IDLE.
REQ-017 HALT SHALL be terminal until reset, with all enables 0 and both counters frozen.
REQ-018 cycles SHALL increment every cycle the state is not IDLE or HALT.
REQ-019 Both counters SHALL wrap modulo 2^64 without flagging.
REQ-020 All outputs SHALL be decoded from registered state and latched flags only, with no combinational path from any input.
REQ-021 fault SHALL be sticky and cleared only by reset.

Reset
REQ-022 Reset SHALL asynchronously force state=IDLE, all enables and retired to 0, instret=0, cycles=0, fault=0, the latched flags to 0 and the timeout counter to 0, at any point, including mid-MEM.
REQ-023 After reset deassertion the first transition SHALL occur on the first rising clk edge with run=1.

Verification
REQ-024 ALU op with IMEM_LAT=1, run=1, dec_reg_write=1, no mem flags -> FETCH,FWAIT,EXEC,WB (4 cycles); one rf_we pulse; instret=1, cycles=4.
REQ-025 Load with dmem_ready asserted on the 3rd MEM cycle -> dmem_req high 3 cycles, dmem_we=0, then WB with rf_we=1; total 7 cycles.
REQ-026 Store with dmem_ready never asserted, MEM_TIMEOUT=16 -> 16 MEM cycles, then state=6, fault=1; instret unchanged afterward.
REQ-027 dec_illegal=1 in EXEC -> HALT next cycle, no pc_we or rf_we; run toggling afterward has no effect until reset.
REQ-028 run dropped during FWAIT -> instruction retires (instret+1), then state=0; reset asserted mid-MEM -> all outputs 0 immediately, without waiting for a clock edge.
REQ-029 Counter preloaded to 2^64-1 via force, then one retire -> instret=0, fault=0.
